// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared types for the execute-stage multi-cycle sequencer: FSM states and
// modular-multiply operand select encodings.
package multi_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SECOND   = 3'd1,
    ST_LSU_WAIT = 3'd2,
    ST_MM_OPS   = 3'd3,
    ST_MM_RES   = 3'd4
  } state_e;

  localparam logic [1:0] MM_SEL_B   = 2'd0;
  localparam logic [1:0] MM_SEL_N   = 2'd1;
  localparam logic [1:0] MM_SEL_A   = 2'd2;
  localparam logic [1:0] MM_SEL_RES = 2'd3;

  // States in which the instruction is waiting on another unit and may time out.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_LSU_WAIT) || (s == ST_MM_OPS) || (s == ST_MM_RES);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_wait_timer.sv
// Saturating wait counter: clear has priority, counts while enabled, fires once
// on the cycle it reaches TIMEOUT_CYCLES and then reports expired until cleared.
module multi_cycle_ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic fire_o,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fire on the cycle whose increment reaches the limit, so the pulse lands on
  // wait cycle TIMEOUT_CYCLES counting the first wait cycle as 1.
  assign fire_o    = en_i && !clr_i && (cnt_q == LIMIT_M1);
  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Execute-stage sequencer: holds retire for two-cycle jumps/taken branches, slow
// LSU transfers and the B/N/A/Result modular-multiply phases; flags wait timeouts.
module multi_cycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_valid_i,
  input  logic       illegal_inst_i,
  input  logic       flush_i,
  input  logic       jump_inst_i,
  input  logic       branch_inst_i,
  input  logic       branch_taken_i,
  input  logic       lsu_req_i,
  input  logic       lsu_ready_i,
  input  logic       mm_start_i,
  input  logic       mm_phase_done_i,
  input  logic       mm_done_i,
  output logic       cycle_counter_o,
  output logic       multi_cycle_op_in_progress_o,
  output logic [1:0] mm_op_address_sel_o,
  output logic       mm_go_o,
  output logic       pc_load_o,
  output logic       instr_done_o,
  output logic       err_timeout_o
);

  import multi_cycle_ctrl_pkg::*;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       go_q, go_d;
  logic       tmr_clr, tmr_en, tmr_fire, tmr_expired;
  logic       hold;

  multi_cycle_ctrl_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .fire_o    (tmr_fire),
    .expired_o (tmr_expired)
  );

  assign tmr_en = is_wait_state(state_q);
  // Once the timeout fires the wait is frozen; only flush can leave it.
  assign hold   = tmr_fire || tmr_expired;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= MM_SEL_B;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    go_d         = 1'b0;
    instr_done_o = 1'b0;
    pc_load_o    = 1'b0;
    tmr_clr      = 1'b0;

    if (flush_i) begin
      state_d = ST_IDLE;
      sel_d   = MM_SEL_B;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmr_clr = 1'b1;
          if (instr_valid_i && !illegal_inst_i) begin
            if (jump_inst_i) begin
              state_d = ST_SECOND;
            end else if (branch_inst_i) begin
              if (branch_taken_i) state_d = ST_SECOND;
              else                instr_done_o = 1'b1;
            end else if (lsu_req_i) begin
              if (lsu_ready_i) instr_done_o = 1'b1;
              else             state_d = ST_LSU_WAIT;
            end else if (mm_start_i) begin
              go_d    = 1'b1;
              sel_d   = MM_SEL_B;
              state_d = ST_MM_OPS;
            end else begin
              instr_done_o = 1'b1;
            end
          end
        end

        ST_SECOND: begin
          tmr_clr      = 1'b1;
          pc_load_o    = 1'b1;
          instr_done_o = 1'b1;
          state_d      = ST_IDLE;
        end

        ST_LSU_WAIT: begin
          if (!hold && lsu_ready_i) begin
            instr_done_o = 1'b1;
            state_d      = ST_IDLE;
          end
        end

        ST_MM_OPS: begin
          if (!hold && mm_phase_done_i) begin
            tmr_clr = 1'b1;
            if (sel_q == MM_SEL_A) begin
              sel_d   = MM_SEL_RES;
              state_d = ST_MM_RES;
            end else begin
              sel_d = sel_q + 2'd1;
            end
          end
        end

        ST_MM_RES: begin
          if (!hold && mm_done_i) begin
            instr_done_o = 1'b1;
            sel_d        = MM_SEL_B;
            state_d      = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          sel_d   = MM_SEL_B;
        end
      endcase
    end
  end

  assign cycle_counter_o              = (state_q == ST_SECOND);
  assign multi_cycle_op_in_progress_o = (state_q != ST_IDLE);
  assign mm_op_address_sel_o          = sel_q;
  assign mm_go_o                      = go_q;
  assign err_timeout_o                = tmr_fire && !flush_i;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl with TIMEOUT_CYCLES=8; outputs packed as
// {cycle_counter, in_progress, sel[1:0], mm_go, pc_load, instr_done, err_timeout}.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, illegal_inst, flush, jump_inst, branch_inst, branch_taken;
  logic       lsu_req, lsu_ready, mm_start, mm_phase_done, mm_done;
  logic       cycle_counter, in_progress, mm_go, pc_load, instr_done, err_timeout;
  logic [1:0] mm_sel;
  logic [7:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i                        (clk),
    .rst_i                        (rst),
    .instr_valid_i                (instr_valid),
    .illegal_inst_i               (illegal_inst),
    .flush_i                      (flush),
    .jump_inst_i                  (jump_inst),
    .branch_inst_i                (branch_inst),
    .branch_taken_i               (branch_taken),
    .lsu_req_i                    (lsu_req),
    .lsu_ready_i                  (lsu_ready),
    .mm_start_i                   (mm_start),
    .mm_phase_done_i              (mm_phase_done),
    .mm_done_i                    (mm_done),
    .cycle_counter_o              (cycle_counter),
    .multi_cycle_op_in_progress_o (in_progress),
    .mm_op_address_sel_o          (mm_sel),
    .mm_go_o                      (mm_go),
    .pc_load_o                    (pc_load),
    .instr_done_o                 (instr_done),
    .err_timeout_o                (err_timeout)
  );

  assign outs = {cycle_counter, in_progress, mm_sel, mm_go, pc_load, instr_done, err_timeout};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_valid = 0; illegal_inst = 0; flush = 0; jump_inst = 0; branch_inst = 0;
    branch_taken = 0; lsu_req = 0; lsu_ready = 0; mm_start = 0; mm_phase_done = 0;
    mm_done = 0;
  endtask

  // Inputs are already driven for this cycle; sample mid-cycle, then advance.
  task automatic expect_cycle(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #3;
    check("reset_outputs", outs, 8'b0_0_00_0_0_0_0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // JAL: link cycle, then PC load + retire, then back to IDLE
    instr_valid = 1; jump_inst = 1;
    expect_cycle("jal_c0", 8'b0_0_00_0_0_0_0);
    clear_inputs();
    expect_cycle("jal_c1", 8'b1_1_00_0_1_1_0);
    expect_cycle("jal_c2", 8'b0_0_00_0_0_0_0);

    // Flush during the second jump cycle suppresses pc_load and retire
    instr_valid = 1; jump_inst = 1;
    expect_cycle("jflush_c0", 8'b0_0_00_0_0_0_0);
    clear_inputs(); flush = 1;
    expect_cycle("jflush_c1", 8'b1_1_00_0_0_0_0);
    flush = 0;
    expect_cycle("jflush_c2", 8'b0_0_00_0_0_0_0);

    // Branch not taken retires in one cycle
    instr_valid = 1; branch_inst = 1;
    expect_cycle("bnt_c0", 8'b0_0_00_0_0_1_0);
    clear_inputs();
    expect_cycle("bnt_c1", 8'b0_0_00_0_0_0_0);

    // Branch taken loads PC in cycle 1
    instr_valid = 1; branch_inst = 1; branch_taken = 1;
    expect_cycle("bt_c0", 8'b0_0_00_0_0_0_0);
    clear_inputs();
    expect_cycle("bt_c1", 8'b1_1_00_0_1_1_0);
    expect_cycle("bt_c2", 8'b0_0_00_0_0_0_0);

    // Load ready on cycle 3
    instr_valid = 1; lsu_req = 1;
    expect_cycle("ld3_c0", 8'b0_0_00_0_0_0_0);
    clear_inputs();
    expect_cycle("ld3_c1", 8'b0_1_00_0_0_0_0);
    expect_cycle("ld3_c2", 8'b0_1_00_0_0_0_0);
    lsu_ready = 1;
    expect_cycle("ld3_c3", 8'b0_1_00_0_0_1_0);
    clear_inputs();
    expect_cycle("ld3_c4", 8'b0_0_00_0_0_0_0);

    // Load ready in the same cycle
    instr_valid = 1; lsu_req = 1; lsu_ready = 1;
    expect_cycle("ld0_c0", 8'b0_0_00_0_0_1_0);
    clear_inputs();
    expect_cycle("ld0_c1", 8'b0_0_00_0_0_0_0);

    // Illegal jump: no retire, stays in IDLE
    instr_valid = 1; illegal_inst = 1; jump_inst = 1;
    expect_cycle("ill_c0", 8'b0_0_00_0_0_0_0);
    clear_inputs();
    expect_cycle("ill_c1", 8'b0_0_00_0_0_0_0);

    // Single-cycle ALU op, then idle with no valid
    instr_valid = 1;
    expect_cycle("alu_c0", 8'b0_0_00_0_0_1_0);
    clear_inputs();
    expect_cycle("novalid", 8'b0_0_00_0_0_0_0);

    // Modular multiply: go pulse, B->N->A->Result, done after 5 Result cycles
    instr_valid = 1; mm_start = 1;
    expect_cycle("mm_c0", 8'b0_0_00_0_0_0_0);
    clear_inputs(); mm_phase_done = 1;
    expect_cycle("mm_go_b", 8'b0_1_00_1_0_0_0);
    mm_phase_done = 0;
    expect_cycle("mm_n_idle", 8'b0_1_01_0_0_0_0);
    mm_phase_done = 1;
    expect_cycle("mm_n_adv", 8'b0_1_01_0_0_0_0);
    expect_cycle("mm_a_adv", 8'b0_1_10_0_0_0_0);
    expect_cycle("mm_res_r1", 8'b0_1_11_0_0_0_0);
    mm_phase_done = 0;
    for (int i = 2; i <= 4; i++) expect_cycle($sformatf("mm_res_r%0d", i), 8'b0_1_11_0_0_0_0);
    mm_done = 1;
    expect_cycle("mm_res_done", 8'b0_1_11_0_0_1_0);
    clear_inputs();
    expect_cycle("mm_after", 8'b0_0_00_0_0_0_0);

    // LSU never ready: timeout on wait cycle 8, hold, then flush out
    instr_valid = 1; lsu_req = 1;
    expect_cycle("to_c0", 8'b0_0_00_0_0_0_0);
    clear_inputs();
    for (int i = 1; i <= 7; i++) expect_cycle($sformatf("to_w%0d", i), 8'b0_1_00_0_0_0_0);
    expect_cycle("to_w8_err", 8'b0_1_00_0_0_0_1);
    lsu_ready = 1;
    expect_cycle("to_hold", 8'b0_1_00_0_0_0_0);
    lsu_ready = 0; flush = 1;
    expect_cycle("to_flush", 8'b0_1_00_0_0_0_0);
    flush = 0;
    expect_cycle("to_idle", 8'b0_0_00_0_0_0_0);

    // Asynchronous reset while MM_OPS has sel=2
    instr_valid = 1; mm_start = 1;
    expect_cycle("rmm_c0", 8'b0_0_00_0_0_0_0);
    clear_inputs(); mm_phase_done = 1;
    expect_cycle("rmm_b", 8'b0_1_00_1_0_0_0);
    expect_cycle("rmm_n", 8'b0_1_01_0_0_0_0);
    mm_phase_done = 0;
    @(negedge clk);
    check("rmm_sel2", outs, 8'b0_1_10_0_0_0_0);
    #1 rst = 1'b1;
    #1;
    check("rmm_async_rst", outs, 8'b0_0_00_0_0_0_0);
    @(posedge clk);
    #1 rst = 1'b0;
    instr_valid = 1;
    expect_cycle("rmm_idle", 8'b0_0_00_0_0_1_0);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
